// File: rtl/btb_update_queue.sv
// btb_update_queue
//   Buffers taken branch resolutions from MEM and issues them one per cycle
//   as BTB writes. It also raises a registered redirect on mispredictions.
//
//   Parameters:
//     DEPTH            queue entries (power of two, >= 2)
//   Ports:
//     clk, reset       rising-edge clock, asynchronous active-high reset
//     resolve_*        resolved branch from MEM (valid/ready handshake)
//     hold             freezes the head / suppresses the BTB write
//     btb_write_pc     head pc   (0 when empty)
//     btb_write_data   head target (0 when empty)
//     btb_write        BTB write strobe, pops the head
//     mispredict       registered one-cycle redirect pulse
//     redirect_pc      registered correct next PC, held until next mispredict
//     count            occupancy
//
//   Optional feature macro: BTB_UPDATE_COALESCE_EN
//     When defined, a taken resolution whose pc matches a pending entry
//     overwrites that entry's target in place instead of enqueueing.
module btb_update_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     resolve_valid,
    input  logic [15:0]              resolve_pc,
    input  logic                     resolve_taken,
    input  logic [15:0]              resolve_target,
    input  logic                     resolve_pred_hit,
    input  logic [15:0]              resolve_pred_pc,
    output logic                     resolve_ready,
    input  logic                     hold,
    output logic [15:0]              btb_write_pc,
    output logic [15:0]              btb_write_data,
    output logic                     btb_write,
    output logic                     mispredict,
    output logic [15:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [15:0]   pc_q  [DEPTH];
    logic [15:0]   tgt_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic          not_empty;
    logic          not_full;
    logic          accept;
    logic          enq;
    logic          mp_next;
    logic [15:0]   rd_next;

    assign not_empty      = (count != '0);
    assign not_full       = (count < CW'(DEPTH));
    assign btb_write      = not_empty & ~hold;
    assign btb_write_pc   = not_empty ? pc_q[rd_ptr]  : '0;
    assign btb_write_data = not_empty ? tgt_q[rd_ptr] : '0;

`ifdef BTB_UPDATE_COALESCE_EN
    logic          coal_hit;
    logic [AW-1:0] coal_idx;

    // Scan from the head toward the tail so the oldest match wins. The head
    // is skipped while it is being written this cycle, since it leaves the
    // queue at this edge and an in-place update would be lost.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!coal_hit && resolve_taken && (CW'(k) < count) &&
                !((k == 0) && btb_write) &&
                (pc_q[rd_ptr + AW'(k)] == resolve_pc)) begin
                coal_hit = 1'b1;
                coal_idx = rd_ptr + AW'(k);
            end
        end
    end

    assign resolve_ready = ~resolve_taken | not_full | coal_hit;
    assign enq           = accept & resolve_taken & ~coal_hit;
`else
    assign resolve_ready = ~resolve_taken | not_full;
    assign enq           = accept & resolve_taken;
`endif

    assign accept = resolve_valid & resolve_ready;

    always_comb begin
        mp_next = 1'b0;
        rd_next = resolve_target;
        if (resolve_taken) begin
            mp_next = ~resolve_pred_hit | (resolve_pred_pc != resolve_target);
        end else begin
            mp_next = resolve_pred_hit;
            rd_next = resolve_pc + 16'd2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                tgt_q[i] <= '0;
            end
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            if (enq) begin
                pc_q[wr_ptr]  <= resolve_pc;
                tgt_q[wr_ptr] <= resolve_target;
                wr_ptr        <= wr_ptr + AW'(1);
            end
`ifdef BTB_UPDATE_COALESCE_EN
            if (accept && coal_hit) begin
                tgt_q[coal_idx] <= resolve_target;
            end
`endif
            if (btb_write) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({enq, btb_write})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            mispredict <= accept & mp_next;
            if (accept && mp_next) begin
                redirect_pc <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_btb_update_queue.sv
// Testbench for btb_update_queue (DEPTH = 4). Expected BTB writes are kept
// in a scoreboard queue filled when resolutions are driven and drained when
// the DUT strobes btb_write. Honours BTB_UPDATE_COALESCE_EN when defined.
module tb_btb_update_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        resolve_valid;
    logic [15:0] resolve_pc;
    logic        resolve_taken;
    logic [15:0] resolve_target;
    logic        resolve_pred_hit;
    logic [15:0] resolve_pred_pc;
    logic        resolve_ready;
    logic        hold;
    logic [15:0] btb_write_pc;
    logic [15:0] btb_write_data;
    logic        btb_write;
    logic        mispredict;
    logic [15:0] redirect_pc;
    logic [2:0]  count;

    btb_update_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .resolve_valid    (resolve_valid),
        .resolve_pc       (resolve_pc),
        .resolve_taken    (resolve_taken),
        .resolve_target   (resolve_target),
        .resolve_pred_hit (resolve_pred_hit),
        .resolve_pred_pc  (resolve_pred_pc),
        .resolve_ready    (resolve_ready),
        .hold             (hold),
        .btb_write_pc     (btb_write_pc),
        .btb_write_data   (btb_write_data),
        .btb_write        (btb_write),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .count            (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] tgt;
    } entry_t;

    entry_t      sb[$];
    int          tests = 0;
    int          fails = 0;
    logic        cur_mp = 1'b0;
    logic [15:0] cur_rd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic tk,
                         input logic [15:0] tgt, input logic hit, input logic [15:0] ppc);
        resolve_valid    = v;
        resolve_pc       = pc;
        resolve_taken    = tk;
        resolve_target   = tgt;
        resolve_pred_hit = hit;
        resolve_pred_pc  = ppc;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    // One clock: check outputs at the falling edge against the model, update
    // the model with this cycle's handshake, then advance past the rising edge.
    task automatic step();
        logic        exp_w;
        logic        exp_rdy;
        logic        match;
        int          midx;
        logic        nxt_mp;
        logic [15:0] nxt_rd;
        entry_t      e;
        int          occ;

        @(negedge clk);
        occ    = sb.size();
        exp_w  = (occ != 0) && !hold;
        nxt_mp = 1'b0;
        nxt_rd = cur_rd;

        check("count", 32'(count), 32'(occ));
        check("mispredict", 32'(mispredict), 32'(cur_mp));
        check("redirect_pc", 32'(redirect_pc), 32'(cur_rd));
        check("btb_write", 32'(btb_write), 32'(exp_w));
        if (occ == 0) begin
            check("empty_pc", 32'(btb_write_pc), 32'h0);
            check("empty_data", 32'(btb_write_data), 32'h0);
        end
        if (exp_w) begin
            e = sb.pop_front();
            check("write_pc", 32'(btb_write_pc), 32'(e.pc));
            check("write_data", 32'(btb_write_data), 32'(e.tgt));
        end

        if (resolve_valid) begin
            match = 1'b0;
            midx  = 0;
`ifdef BTB_UPDATE_COALESCE_EN
            if (resolve_taken) begin
                for (int i = 0; i < sb.size(); i++) begin
                    if (!match && sb[i].pc == resolve_pc) begin
                        match = 1'b1;
                        midx  = i;
                    end
                end
            end
`endif
            exp_rdy = !resolve_taken || (occ < DEPTH) || match;
            check("resolve_ready", 32'(resolve_ready), 32'(exp_rdy));
            if (exp_rdy) begin
                if (resolve_taken) begin
                    if (match) sb[midx].tgt = resolve_target;
                    else       sb.push_back('{pc: resolve_pc, tgt: resolve_target});
                    nxt_mp = !resolve_pred_hit || (resolve_pred_pc != resolve_target);
                    if (nxt_mp) nxt_rd = resolve_target;
                end else begin
                    nxt_mp = resolve_pred_hit;
                    if (nxt_mp) nxt_rd = resolve_pc + 16'd2;
                end
            end
        end

        @(posedge clk);
        #1;
        cur_mp = nxt_mp;
        cur_rd = nxt_rd;
    endtask

    initial begin
        hold  = 1'b0;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset: outputs zero, taken resolution would be accepted.
        resolve_taken = 1'b1;
        #1;
        check("idle_ready", 32'(resolve_ready), 32'h1);
        idle();
        step();

        // Single taken resolution, not predicted: write + redirect next cycle.
        drive(1'b1, 16'h3000, 1'b1, 16'h3040, 1'b0, 16'h0);
        step();
        idle();
        step();
        step();

        // Fill under hold, fifth taken refused, not-taken still accepted.
        hold = 1'b1;
        drive(1'b1, 16'h1000, 1'b1, 16'h1100, 1'b1, 16'h1100); step();
        drive(1'b1, 16'h1002, 1'b1, 16'h1200, 1'b1, 16'h1200); step();
        drive(1'b1, 16'h1004, 1'b1, 16'h1300, 1'b1, 16'h1300); step();
        drive(1'b1, 16'h1006, 1'b1, 16'h1400, 1'b1, 16'h1400); step();
        drive(1'b1, 16'h1008, 1'b1, 16'h1500, 1'b0, 16'h0);    step();
        drive(1'b1, 16'h100A, 1'b0, 16'h0,    1'b0, 16'h0);    step();
        idle();
        hold = 1'b0;
        repeat (6) step();

        // Not taken but predicted taken at the top of memory: pc+2 wraps.
        drive(1'b1, 16'hFFFE, 1'b0, 16'h0, 1'b1, 16'h1234);
        step();
        idle();
        repeat (2) step();

        // Correct prediction, then a wrong-target prediction.
        drive(1'b1, 16'h2000, 1'b1, 16'h4000, 1'b1, 16'h4000); step();
        idle(); repeat (2) step();
        drive(1'b1, 16'h2010, 1'b1, 16'h4000, 1'b1, 16'h4004); step();
        idle(); repeat (2) step();

        // Same pc twice while held.
        hold = 1'b1;
        drive(1'b1, 16'h3000, 1'b1, 16'h3100, 1'b0, 16'h0); step();
        drive(1'b1, 16'h3000, 1'b1, 16'h3200, 1'b0, 16'h0); step();
        idle();
        #1;
`ifdef BTB_UPDATE_COALESCE_EN
        check("coalesce_count", 32'(count), 32'h1);
`else
        check("coalesce_count", 32'(count), 32'h2);
`endif
        hold = 1'b0;
        repeat (3) step();

        // Back-to-back traffic with random hold and a small pc pool.
        for (int n = 0; n < 60; n++) begin
            hold = ($urandom_range(0, 3) == 0);
            drive(1'($urandom_range(0, 1)), 16'h5000 + 16'($urandom_range(0, 5) * 2),
                  1'($urandom_range(0, 3) != 0), 16'($urandom),
                  1'($urandom_range(0, 1)), 16'($urandom_range(0, 1) ? 16'h0 : 16'h6000));
            step();
        end
        idle();
        hold = 1'b0;
        repeat (6) step();

        // Asynchronous reset with pending entries.
        hold = 1'b1;
        drive(1'b1, 16'h7000, 1'b1, 16'h7100, 1'b0, 16'h0); step();
        drive(1'b1, 16'h7002, 1'b1, 16'h7200, 1'b0, 16'h0); step();
        idle();
        hold = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'h0);
        check("rst_write", 32'(btb_write), 32'h0);
        check("rst_mispredict", 32'(mispredict), 32'h0);
        check("rst_redirect", 32'(redirect_pc), 32'h0);
        sb.delete();
        cur_mp = 1'b0;
        cur_rd = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) step();

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/btb_update_queue.md
# btb_update_queue

Buffers resolved branch outcomes from the MEM stage and issues them, one per cycle, as writes into the 4-way branch target buffer that feeds the fetch stage. It also detects mispredictions and produces a registered redirect toward fetch. It sits directly upstream of the BTB write port (`write_pc`, `write_data`, `taken`), so BTB updates never stall the resolving stage unless the queue is full.

## Interface
- `DEPTH`, default 4: queue entries; must be a power of two, ≥2.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `resolve_valid` in 1: MEM stage presents a resolved control-flow instruction.
- `resolve_pc` in 16: PC of the branch.
- `resolve_taken` in 1: actual outcome.
- `resolve_target` in 16: actual target; meaningful only when taken.
- `resolve_pred_hit` in 1: BTB hit recorded at fetch, which means predicted taken.
- `resolve_pred_pc` in 16: predicted target recorded at fetch.
- `resolve_ready` out 1: handshake accepted when `resolve_valid & resolve_ready`.
- `hold` in 1: suppresses the BTB write this cycle.
- `btb_write_pc` out 16: drives BTB `write_pc`.
- `btb_write_data` out 16: drives BTB `write_data`.
- `btb_write` out 1: drives BTB `taken`, the write strobe.
- `mispredict` out 1: registered one-cycle redirect pulse.
- `redirect_pc` out 16: registered correct next PC.
- `count` out log2(DEPTH)+1: occupancy.

## Operation
- Only taken resolutions are enqueued; not-taken resolutions never consume space.
- `resolve_ready = !resolve_taken | (count < DEPTH)`, plus the coalesce case described below. Not-taken resolutions are always accepted.
- Each entry holds `{pc, target}`. The queue is a circular FIFO with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
- Head is presented combinationally: `btb_write = (count != 0) & !hold`, with `btb_write_pc` and `btb_write_data` taken from the head slot. The head pops on any cycle where `btb_write` is 1.
- When empty, `btb_write_pc` and `btb_write_data` are 0.
- Simultaneous enqueue and dequeue: `count` is unchanged and both pointers advance. This is legal even at `count == DEPTH`, but a full queue still deasserts `resolve_ready` for taken resolutions, so enqueue is never accepted when full.
- Misprediction is evaluated on every accepted handshake:
  - Taken, not hit: mispredict, `redirect_pc = resolve_target`.
  - Taken, hit, `resolve_pred_pc != resolve_target`: mispredict, `redirect_pc = resolve_target`.
  - Not taken, hit: mispredict, `redirect_pc = resolve_pc + 2`, computed in 16 bits with wrap (0xFFFE → 0x0000).
  - Otherwise: no mispredict.
- Not-taken-with-hit predictions are reported but cause no BTB write. This block does not invalidate BTB entries.

## Timing
- Reset values: all queue slots and pointers 0, `count` 0, `btb_write` 0, `btb_write_pc` and `btb_write_data` 0, `mispredict` 0, `redirect_pc` 0.
- Reset asserted mid-operation discards all pending entries immediately, with no partial writes after release.
- Enqueue at edge N places the entry at head no earlier than cycle N+1. Minimum resolve-to-BTB-write latency is 1 cycle, and no bypass exists.
- `mispredict` and `redirect_pc` are registered: a handshake in cycle N produces a pulse in cycle N+1, lasting one cycle. `redirect_pc` holds its value until the next mispredict.
- `hold` freezes the head. Entries are never dropped while `hold` is asserted, and enqueue continues.
- Throughput: one enqueue and one BTB write per cycle.

## Configuration
- `BTB_UPDATE_COALESCE_EN` defined: a taken resolution whose `resolve_pc` equals any valid pending entry's pc overwrites that entry's target in place.
  - No enqueue occurs, and `count` is unchanged.
  - The resolution is accepted even when the queue is full.
  - The head slot is excluded from matching in any cycle where `btb_write` is 1; the new resolution enqueues normally instead.
  - Only the oldest matching slot is updated.
- Undefined: no matching is performed, and duplicates are enqueued as separate entries.

## Test plan
- Reset then idle: all outputs 0, and `resolve_ready` is 1 for a taken resolution.
- Enqueue taken pc=0x3000, target 0x3040, `pred_hit=0`:
  - Next cycle: `btb_write=1`, pc 0x3000, data 0x3040, `mispredict=1`, `redirect_pc=0x3040`.
  - Following cycle: `count=0`.
- Hold asserted, 4 taken resolutions enqueued:
  - `count=4`, and `resolve_ready=0` for a 5th taken resolution.
  - A not-taken resolution is still accepted.
  - Release hold: 4 writes in FIFO order on consecutive cycles, pointers wrapping correctly.
- Not taken with `pred_hit=1` at pc=0xFFFE: no BTB write, `mispredict=1`, `redirect_pc=0x0000`.
- Correct prediction (taken, hit, `pred_pc == target` = 0x4000): `mispredict` stays 0, and one BTB write occurs.
- With `BTB_UPDATE_COALESCE_EN`, hold=1, enqueue pc=0x3000 with target 0x3100, then pc=0x3000 with target 0x3200:
  - `count=1`.
  - Release: a single write of data 0x3200.
  - Without the macro: two writes, 0x3100 then 0x3200.
